// File: rtl/usb_rx_pkt_decoder.sv
// USB receive packet decoder: takes destuffed LSB-first bits between SYNC and EOP,
// classifies the PID, extracts token/SOF fields, streams DATA payload and checks CRC5/CRC16.
module usb_rx_pkt_decoder #(
    parameter int MAX_PKT_BYTES = 64,
    parameter int CHECK_CRC     = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_packet_st_i,
    input  logic        rx_packet_ed_i,
    input  logic        rx_data_i,
    input  logic        rx_den_i,
    output logic [3:0]  rx_pid_o,
    output logic [1:0]  rx_packet_type_o,
    output logic [6:0]  rx_addr_o,
    output logic [3:0]  rx_endp_o,
    output logic [10:0] rx_frame_o,
    output logic [7:0]  rx_byte_o,
    output logic        rx_byte_vld_o,
    output logic [10:0] rx_byte_cnt_o,
    output logic        rx_pkt_done_o,
    output logic        rx_pid_error_o,
    output logic        rx_crc_error_o,
    output logic        rx_len_error_o
);

    typedef enum logic [2:0] {IDLE, PID, TOKEN, DATA, HSHK, DROP} state_t;

    localparam logic [10:0] MAX_CNT   = 11'(MAX_PKT_BYTES);
    localparam logic [4:0]  CRC5_RES  = 5'b01100;
    localparam logic [15:0] CRC16_RES = 16'h800D;

    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  pid_sr_q, pid_sr_d;
    logic [10:0] tok_q, tok_d;
    logic [4:0]  crc5_q, crc5_d;
    logic [15:0] crc16_q, crc16_d;
    logic [6:0]  byte_sr_q, byte_sr_d;
    logic [7:0]  hold0_q, hold0_d, hold1_q, hold1_d;
    logic [1:0]  hold_cnt_q, hold_cnt_d;
    logic        pid_err_q, pid_err_d, len_err_q, len_err_d;
    logic [3:0]  pid_q, pid_d;
    logic [1:0]  type_q, type_d;
    logic [6:0]  addr_q, addr_d;
    logic [3:0]  endp_q, endp_d;
    logic [10:0] frame_q, frame_d;
    logic [7:0]  out_byte_q, out_byte_d;
    logic        byte_vld_q, byte_vld_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic        done_q, done_d;
    logic        err_pid_q, err_pid_d, err_crc_q, err_crc_d, err_len_q, err_len_d;

    logic [7:0]  pid_full, new_byte;
    logic [1:0]  pid_type;
    logic        pid_ok, fin_len, fin_crc;

    assign pid_full = {rx_data_i, pid_sr_q};
    assign new_byte = {rx_data_i, byte_sr_q};

    always_comb begin
        pid_type = 2'd0;
        pid_ok   = 1'b1;
        case (pid_full[3:0])
            4'b0001, 4'b1001, 4'b1101: pid_type = 2'd1;
            4'b0101:                   pid_type = 2'd0;
            4'b0011, 4'b1011:          pid_type = 2'd2;
            4'b0010, 4'b1010, 4'b1110: pid_type = 2'd3;
            default:                   pid_ok   = 1'b0;
        endcase
        if (pid_full[7:4] != ~pid_full[3:0]) pid_ok = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        pid_sr_d   = pid_sr_q;
        tok_d      = tok_q;
        crc5_d     = crc5_q;
        crc16_d    = crc16_q;
        byte_sr_d  = byte_sr_q;
        hold0_d    = hold0_q;
        hold1_d    = hold1_q;
        hold_cnt_d = hold_cnt_q;
        pid_err_d  = pid_err_q;
        len_err_d  = len_err_q;
        pid_d      = pid_q;
        type_d     = type_q;
        addr_d     = addr_q;
        endp_d     = endp_q;
        frame_d    = frame_q;
        out_byte_d = out_byte_q;
        byte_vld_d = 1'b0;
        byte_cnt_d = byte_cnt_q;
        done_d     = 1'b0;
        err_pid_d  = err_pid_q;
        err_crc_d  = err_crc_q;
        err_len_d  = err_len_q;
        fin_len    = 1'b0;
        fin_crc    = 1'b0;

        if (state_q != IDLE) begin
            // The bit of this cycle is consumed before any EOP/SYNC finalisation below.
            if (rx_den_i) begin
                case (state_q)
                    PID: begin
                        pid_sr_d  = {rx_data_i, pid_sr_q[6:1]};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            pid_d     = pid_full[3:0];
                            bit_cnt_d = '0;
                            if (pid_ok) begin
                                type_d  = pid_type;
                                state_d = (pid_type == 2'd2) ? DATA :
                                          (pid_type == 2'd3) ? HSHK : TOKEN;
                            end else begin
                                pid_err_d = 1'b1;
                                state_d   = DROP;
                            end
                        end
                    end
                    TOKEN: begin
                        crc5_d = {crc5_q[3:0], 1'b0} ^ ((crc5_q[4] ^ rx_data_i) ? 5'b00101 : 5'b0);
                        if (bit_cnt_q < 5'd11) tok_d = {rx_data_i, tok_q[10:1]};
                        if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                    DATA: begin
                        crc16_d   = {crc16_q[14:0], 1'b0} ^ ((crc16_q[15] ^ rx_data_i) ? 16'h8005 : 16'h0);
                        byte_sr_d = {rx_data_i, byte_sr_q[6:1]};
                        bit_cnt_d = {2'b00, bit_cnt_q[2:0] + 3'd1};
                        if (bit_cnt_q[2:0] == 3'd7) begin
                            // Two-byte holdback keeps the trailing CRC16 off the byte stream.
                            if (hold_cnt_q == 2'd2) begin
                                if (!len_err_q) begin
                                    if (byte_cnt_q == MAX_CNT) begin
                                        len_err_d = 1'b1;
                                    end else begin
                                        out_byte_d = hold0_q;
                                        byte_vld_d = 1'b1;
                                        byte_cnt_d = byte_cnt_q + 11'd1;
                                    end
                                end
                                hold0_d = hold1_q;
                                hold1_d = new_byte;
                            end else if (hold_cnt_q == 2'd1) begin
                                hold1_d    = new_byte;
                                hold_cnt_d = 2'd2;
                            end else begin
                                hold0_d    = new_byte;
                                hold_cnt_d = 2'd1;
                            end
                        end
                    end
                    HSHK:    len_err_d = 1'b1;
                    default: ;
                endcase
            end

            if (rx_packet_ed_i || rx_packet_st_i) begin
                case (state_d)
                    PID:   fin_len = 1'b1;
                    TOKEN: begin
                        fin_len = (bit_cnt_d != 5'd16);
                        fin_crc = (crc5_d != CRC5_RES);
                    end
                    DATA: begin
                        fin_len = len_err_d || (bit_cnt_d[2:0] != 3'd0) || (hold_cnt_d != 2'd2);
                        fin_crc = (crc16_d != CRC16_RES);
                    end
                    HSHK:    fin_len = len_err_d;
                    default: ;
                endcase
                if (rx_packet_st_i) fin_len = 1'b1;
                if (CHECK_CRC == 0) fin_crc = 1'b0;
                done_d    = 1'b1;
                err_pid_d = pid_err_d;
                err_crc_d = fin_crc;
                err_len_d = fin_len;
                if (state_d == TOKEN && !fin_len && !fin_crc) begin
                    if (type_d == 2'd0) begin
                        frame_d = tok_d;
                    end else begin
                        addr_d = tok_d[6:0];
                        endp_d = tok_d[10:7];
                    end
                end
                state_d = IDLE;
            end
        end

        if (rx_packet_st_i) begin
            state_d    = PID;
            bit_cnt_d  = '0;
            crc5_d     = 5'h1F;
            crc16_d    = 16'hFFFF;
            byte_cnt_d = '0;
            hold_cnt_d = '0;
            pid_err_d  = 1'b0;
            len_err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            pid_sr_q   <= '0;
            tok_q      <= '0;
            crc5_q     <= 5'h1F;
            crc16_q    <= 16'hFFFF;
            byte_sr_q  <= '0;
            hold0_q    <= '0;
            hold1_q    <= '0;
            hold_cnt_q <= '0;
            pid_err_q  <= 1'b0;
            len_err_q  <= 1'b0;
            pid_q      <= '0;
            type_q     <= '0;
            addr_q     <= '0;
            endp_q     <= '0;
            frame_q    <= '0;
            out_byte_q <= '0;
            byte_vld_q <= 1'b0;
            byte_cnt_q <= '0;
            done_q     <= 1'b0;
            err_pid_q  <= 1'b0;
            err_crc_q  <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            pid_sr_q   <= pid_sr_d;
            tok_q      <= tok_d;
            crc5_q     <= crc5_d;
            crc16_q    <= crc16_d;
            byte_sr_q  <= byte_sr_d;
            hold0_q    <= hold0_d;
            hold1_q    <= hold1_d;
            hold_cnt_q <= hold_cnt_d;
            pid_err_q  <= pid_err_d;
            len_err_q  <= len_err_d;
            pid_q      <= pid_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            endp_q     <= endp_d;
            frame_q    <= frame_d;
            out_byte_q <= out_byte_d;
            byte_vld_q <= byte_vld_d;
            byte_cnt_q <= byte_cnt_d;
            done_q     <= done_d;
            err_pid_q  <= err_pid_d;
            err_crc_q  <= err_crc_d;
            err_len_q  <= err_len_d;
        end
    end

    assign rx_pid_o         = pid_q;
    assign rx_packet_type_o = type_q;
    assign rx_addr_o        = addr_q;
    assign rx_endp_o        = endp_q;
    assign rx_frame_o       = frame_q;
    assign rx_byte_o        = out_byte_q;
    assign rx_byte_vld_o    = byte_vld_q;
    assign rx_byte_cnt_o    = byte_cnt_q;
    assign rx_pkt_done_o    = done_q;
    assign rx_pid_error_o   = err_pid_q;
    assign rx_crc_error_o   = err_crc_q;
    assign rx_len_error_o   = err_len_q;

endmodule

// File: tb/tb_usb_rx_pkt_decoder.sv
// Directed bench for usb_rx_pkt_decoder: default instance plus a MAX_PKT_BYTES=4 instance
// sharing the same bit stream; done records and byte strobes are logged at the falling edge.
module tb_usb_rx_pkt_decoder;

    typedef struct packed {
        logic [3:0]  pid;
        logic [1:0]  typ;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [10:0] frame;
        logic [10:0] cnt;
        logic        pe;
        logic        ce;
        logic        le;
    } done_t;

    logic clk = 1'b0;
    logic rst, st, ed, den, dat;

    logic [3:0]  pid_o, pid4_o;
    logic [1:0]  type_o, type4_o;
    logic [6:0]  addr_o, addr4_o;
    logic [3:0]  endp_o, endp4_o;
    logic [10:0] frame_o, frame4_o;
    logic [7:0]  byte_o, byte4_o;
    logic        vld_o, vld4_o;
    logic [10:0] cnt_o, cnt4_o;
    logic        done_o, done4_o;
    logic        pe_o, pe4_o, ce_o, ce4_o, le_o, le4_o;

    int tests_run = 0;
    int failed    = 0;

    done_t      dones[$];
    done_t      dones4[$];
    logic [7:0] strobes[$];
    logic [7:0] strobes4[$];
    logic [7:0] pkt_q[$];

    always #5 clk = ~clk;

    usb_rx_pkt_decoder u_dut (
        .clk_i(clk), .rst_i(rst), .rx_packet_st_i(st), .rx_packet_ed_i(ed),
        .rx_data_i(dat), .rx_den_i(den), .rx_pid_o(pid_o), .rx_packet_type_o(type_o),
        .rx_addr_o(addr_o), .rx_endp_o(endp_o), .rx_frame_o(frame_o), .rx_byte_o(byte_o),
        .rx_byte_vld_o(vld_o), .rx_byte_cnt_o(cnt_o), .rx_pkt_done_o(done_o),
        .rx_pid_error_o(pe_o), .rx_crc_error_o(ce_o), .rx_len_error_o(le_o)
    );

    usb_rx_pkt_decoder #(.MAX_PKT_BYTES(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .rx_packet_st_i(st), .rx_packet_ed_i(ed),
        .rx_data_i(dat), .rx_den_i(den), .rx_pid_o(pid4_o), .rx_packet_type_o(type4_o),
        .rx_addr_o(addr4_o), .rx_endp_o(endp4_o), .rx_frame_o(frame4_o), .rx_byte_o(byte4_o),
        .rx_byte_vld_o(vld4_o), .rx_byte_cnt_o(cnt4_o), .rx_pkt_done_o(done4_o),
        .rx_pid_error_o(pe4_o), .rx_crc_error_o(ce4_o), .rx_len_error_o(le4_o)
    );

    always @(negedge clk) begin
        if (vld_o)  strobes.push_back(byte_o);
        if (vld4_o) strobes4.push_back(byte4_o);
        if (done_o)
            dones.push_back(done_t'({pid_o, type_o, addr_o, endp_o, frame_o, cnt_o, pe_o, ce_o, le_o}));
        if (done4_o)
            dones4.push_back(done_t'({pid4_o, type4_o, addr4_o, endp4_o, frame4_o, cnt4_o, pe4_o, ce4_o, le4_o}));
    end

    task automatic drv(input logic s, input logic e, input logic v, input logic b);
        st = s; ed = e; den = v; dat = b;
        @(negedge clk);
    endtask

    task automatic send_bits(input int nbits, input bit ed_same);
        logic [7:0] cur;
        for (int i = 0; i < nbits; i++) begin
            cur = pkt_q[i / 8];
            drv(1'b0, ed_same && (i == nbits - 1), 1'b1, cur[i % 8]);
        end
    endtask

    task automatic send_pkt(input int nbits, input bit ed_same);
        drv(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(nbits, ed_same);
        if (!(ed_same && nbits > 0)) drv(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) drv(1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] pkt pid_byte=%02h bits=%0d dones=%0d strobes=%0d", pkt_q[0], nbits, dones.size(), strobes.size());
    endtask

    task automatic test_reset;
        tests_run++;
        if ({pid_o, type_o, addr_o, endp_o, frame_o, byte_o, vld_o, cnt_o, done_o, pe_o, ce_o, le_o} !== 52'd0) begin
            failed++; $display("FAIL reset_outputs: got %0h expected 0",
                {pid_o, type_o, addr_o, endp_o, frame_o, byte_o, vld_o, cnt_o, done_o, pe_o, ce_o, le_o});
        end
        tests_run++;
        if ({pid4_o, type4_o, addr4_o, endp4_o, frame4_o, byte4_o, vld4_o, cnt4_o, done4_o, pe4_o, ce4_o, le4_o} !== 52'd0) begin
            failed++; $display("FAIL reset_outputs4: got nonzero expected 0");
        end
    endtask

    task automatic test_token;
        int n0;
        done_t d;
        n0 = dones.size();
        pkt_q = '{8'h2D, 8'h00, 8'h10}; send_pkt(24, 0);
        pkt_q = '{8'hE1, 8'h85, 8'h60}; send_pkt(24, 0);
        pkt_q = '{8'h2D, 8'h00, 8'h11}; send_pkt(24, 0);
        tests_run++;
        if (dones.size() !== n0 + 3) begin failed++; $display("FAIL token_done_count: got %0d expected 3", dones.size() - n0); end
        d = (dones.size() > n0) ? dones[n0] : '0;
        tests_run++;
        if ({d.pid, d.typ, d.addr, d.endp, d.pe, d.ce, d.le} !== {4'hD, 2'd1, 7'd0, 4'd0, 3'b000}) begin
            failed++; $display("FAIL setup_fields: got %0h expected %0h", {d.pid, d.typ, d.addr, d.endp, d.pe, d.ce, d.le}, {4'hD, 2'd1, 7'd0, 4'd0, 3'b000});
        end
        d = (dones.size() > n0 + 1) ? dones[n0 + 1] : '0;
        tests_run++;
        if ({d.pid, d.typ, d.addr, d.endp, d.pe, d.ce, d.le} !== {4'h1, 2'd1, 7'd5, 4'd1, 3'b000}) begin
            failed++; $display("FAIL out_fields: got %0h expected %0h", {d.pid, d.typ, d.addr, d.endp, d.pe, d.ce, d.le}, {4'h1, 2'd1, 7'd5, 4'd1, 3'b000});
        end
        d = (dones.size() > n0 + 2) ? dones[n0 + 2] : '0;
        tests_run++;
        if ({d.ce, d.le, d.addr, d.endp} !== {1'b1, 1'b0, 7'd5, 4'd1}) begin
            failed++; $display("FAIL setup_crc_err_hold: got ce=%0b le=%0b addr=%0h endp=%0h expected ce=1 le=0 addr=5 endp=1", d.ce, d.le, d.addr, d.endp);
        end
    endtask

    task automatic test_sof;
        int n0;
        done_t d;
        n0 = dones.size();
        pkt_q = '{8'hA5, 8'h85, 8'h60}; send_pkt(24, 0);
        d = (dones.size() > n0) ? dones[n0] : '0;
        tests_run++;
        if ({d.typ, d.frame, d.addr, d.endp, d.pe, d.ce, d.le} !== {2'd0, 11'h085, 7'd5, 4'd1, 3'b000}) begin
            failed++; $display("FAIL sof_fields: got typ=%0d frame=%0h addr=%0h err=%0b%0b%0b expected typ=0 frame=085 addr=5 err=000",
                d.typ, d.frame, d.addr, d.pe, d.ce, d.le);
        end
    endtask

    task automatic test_data(input bit ed_same);
        int n0, s0;
        done_t d;
        logic [7:0] exp_b[$];
        exp_b = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
        n0 = dones.size(); s0 = strobes.size();
        pkt_q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        send_pkt(88, ed_same);
        tests_run++;
        if (strobes.size() - s0 !== 8) begin failed++; $display("FAIL data_strobe_count(ed_same=%0b): got %0d expected 8", ed_same, strobes.size() - s0); end
        for (int i = 0; i < 8; i++) begin
            if (strobes.size() > s0 + i) begin
                tests_run++;
                if (strobes[s0 + i] !== exp_b[i]) begin
                    failed++; $display("FAIL data_byte%0d: got %02h expected %02h", i, strobes[s0 + i], exp_b[i]);
                end
            end
        end
        d = (dones.size() > n0) ? dones[n0] : '0;
        tests_run++;
        if ({d.pid, d.typ, d.cnt, d.pe, d.ce, d.le} !== {4'h3, 2'd2, 11'd8, 3'b000}) begin
            failed++; $display("FAIL data_status(ed_same=%0b): got pid=%0h typ=%0d cnt=%0d err=%0b%0b%0b expected pid=3 typ=2 cnt=8 err=000",
                ed_same, d.pid, d.typ, d.cnt, d.pe, d.ce, d.le);
        end
    endtask

    task automatic test_hshk;
        int n0;
        done_t d;
        n0 = dones.size();
        pkt_q = '{8'hD2, 8'h07}; send_pkt(8, 0);
        send_pkt(11, 0);
        d = (dones.size() > n0) ? dones[n0] : '0;
        tests_run++;
        if ({d.pid, d.typ, d.pe, d.ce, d.le} !== {4'h2, 2'd3, 3'b000}) begin
            failed++; $display("FAIL ack_clean: got pid=%0h typ=%0d err=%0b%0b%0b expected pid=2 typ=3 err=000", d.pid, d.typ, d.pe, d.ce, d.le);
        end
        d = (dones.size() > n0 + 1) ? dones[n0 + 1] : '0;
        tests_run++;
        if ({d.typ, d.le} !== {2'd3, 1'b1}) begin
            failed++; $display("FAIL ack_extra_bits: got typ=%0d le=%0b expected typ=3 le=1", d.typ, d.le);
        end
    endtask

    task automatic test_pid_error;
        int n0, s0;
        done_t d;
        n0 = dones.size(); s0 = strobes.size();
        pkt_q = '{8'h3C, 8'h80, 8'h06, 8'h00, 8'h01}; send_pkt(40, 0);
        d = (dones.size() > n0) ? dones[n0] : '0;
        tests_run++;
        if ({d.pe, strobes.size() - s0} !== {1'b1, 32'd0}) begin
            failed++; $display("FAIL pid_error: got pe=%0b strobes=%0d expected pe=1 strobes=0", d.pe, strobes.size() - s0);
        end
    endtask

    task automatic test_short;
        int n0;
        done_t d;
        n0 = dones.size();
        pkt_q = '{8'hD2}; send_pkt(5, 0);
        pkt_q = '{8'h2D, 8'h00, 8'h10}; send_pkt(23, 0);
        d = (dones.size() > n0) ? dones[n0] : '0;
        tests_run++;
        if ({d.pe, d.le} !== 2'b01) begin failed++; $display("FAIL short_pid: got pe=%0b le=%0b expected pe=0 le=1", d.pe, d.le); end
        d = (dones.size() > n0 + 1) ? dones[n0 + 1] : '0;
        tests_run++;
        if ({d.le, d.addr, d.endp} !== {1'b1, 7'd5, 4'd1}) begin
            failed++; $display("FAIL short_token: got le=%0b addr=%0h endp=%0h expected le=1 addr=5 endp=1", d.le, d.addr, d.endp);
        end
    endtask

    task automatic test_max_len;
        int n0, n4, s0, s4;
        done_t d;
        n0 = dones.size(); n4 = dones4.size(); s0 = strobes.size(); s4 = strobes4.size();
        pkt_q = '{8'h4B, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hAA, 8'hBB}; send_pkt(72, 0);
        d = (dones4.size() > n4) ? dones4[n4] : '0;
        tests_run++;
        if ({strobes4.size() - s4, d.cnt, d.le} !== {32'd4, 11'd4, 1'b1}) begin
            failed++; $display("FAIL max4_overflow: got strobes=%0d cnt=%0d le=%0b expected strobes=4 cnt=4 le=1", strobes4.size() - s4, d.cnt, d.le);
        end
        tests_run++;
        if (strobes4.size() >= s4 + 4 && strobes4[s4 + 3] !== 8'h44) begin
            failed++; $display("FAIL max4_last_byte: got %02h expected 44", strobes4[s4 + 3]);
        end
        d = (dones.size() > n0) ? dones[n0] : '0;
        tests_run++;
        if ({strobes.size() - s0, d.cnt, d.le} !== {32'd6, 11'd6, 1'b0}) begin
            failed++; $display("FAIL max64_six_bytes: got strobes=%0d cnt=%0d le=%0b expected strobes=6 cnt=6 le=0", strobes.size() - s0, d.cnt, d.le);
        end
        n4 = dones4.size(); s4 = strobes4.size();
        pkt_q = '{8'h4B, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB}; send_pkt(56, 0);
        d = (dones4.size() > n4) ? dones4[n4] : '0;
        tests_run++;
        if ({strobes4.size() - s4, d.cnt, d.le} !== {32'd4, 11'd4, 1'b0}) begin
            failed++; $display("FAIL max4_exact: got strobes=%0d cnt=%0d le=%0b expected strobes=4 cnt=4 le=0", strobes4.size() - s4, d.cnt, d.le);
        end
    endtask

    task automatic test_back_to_back;
        int n0, s0;
        done_t d;
        n0 = dones.size(); s0 = strobes.size();
        pkt_q = '{8'hC3, 8'h80, 8'h06};
        drv(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(24, 0);
        pkt_q = '{8'hD2};
        drv(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8, 0);
        drv(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) drv(1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] pkt back_to_back data+ack dones=%0d", dones.size());
        tests_run++;
        if ({dones.size() - n0, strobes.size() - s0} !== {32'd2, 32'd0}) begin
            failed++; $display("FAIL b2b_counts: got dones=%0d strobes=%0d expected dones=2 strobes=0", dones.size() - n0, strobes.size() - s0);
        end
        d = (dones.size() > n0) ? dones[n0] : '0;
        tests_run++;
        if (d.le !== 1'b1) begin failed++; $display("FAIL b2b_first_len: got %0b expected 1", d.le); end
        d = (dones.size() > n0 + 1) ? dones[n0 + 1] : '0;
        tests_run++;
        if ({d.typ, d.pe, d.ce, d.le} !== {2'd3, 3'b000}) begin
            failed++; $display("FAIL b2b_second_ack: got typ=%0d err=%0b%0b%0b expected typ=3 err=000", d.typ, d.pe, d.ce, d.le);
        end
    endtask

    task automatic test_reset_mid;
        int n0, s0;
        done_t d;
        n0 = dones.size(); s0 = strobes.size();
        pkt_q = '{8'hC3, 8'h80, 8'h06, 8'h00};
        drv(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(28, 0);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({done_o, vld_o, cnt_o, addr_o, type_o, pid_o} !== 29'd0) begin
            failed++; $display("FAIL midreset_outputs: got %0h expected 0", {done_o, vld_o, cnt_o, addr_o, type_o, pid_o});
        end
        @(negedge clk);
        rst = 1'b0;
        pkt_q = '{8'hD2};
        send_bits(8, 0);
        drv(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) drv(1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] pkt reset_mid then bits without sync dones=%0d", dones.size());
        tests_run++;
        if ({dones.size() - n0, strobes.size() - s0} !== {32'd0, 32'd0}) begin
            failed++; $display("FAIL midreset_no_done: got dones=%0d strobes=%0d expected 0 0", dones.size() - n0, strobes.size() - s0);
        end
        send_pkt(8, 0);
        d = (dones.size() > n0) ? dones[n0] : '0;
        tests_run++;
        if ({dones.size() - n0, d.typ, d.pe, d.ce, d.le} !== {32'd1, 2'd3, 3'b000}) begin
            failed++; $display("FAIL midreset_recover: got dones=%0d typ=%0d err=%0b%0b%0b expected dones=1 typ=3 err=000",
                dones.size() - n0, d.typ, d.pe, d.ce, d.le);
        end
    endtask

    initial begin
        rst = 1'b1; st = 1'b0; ed = 1'b0; den = 1'b0; dat = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b0;
        @(negedge clk);
        test_token;
        test_sof;
        test_data(1'b0);
        test_data(1'b1);
        test_hshk;
        test_pid_error;
        test_short;
        test_max_len;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/usb_rx_pkt_decoder.md
USB_RX_PKT_DECODER -- requirements
Module: usb_rx_pkt_decoder

Interface
REQ-001 SHALL have parameter MAX_PKT_BYTES, default 64, max DATA payload bytes (CRC excluded), range 1..1023.
REQ-002 SHALL have parameter CHECK_CRC, default 1, where 1 enables CRC5/CRC16 checks and 0 forces rx_crc_error_o=0.
REQ-003 SHALL have port clk_i, in, 1, system clock (24 MHz).
REQ-004 SHALL have port rst_i, in, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port rx_packet_st_i, in, 1, 1-clk pulse after SYNC detected.
REQ-006 SHALL have port rx_packet_ed_i, in, 1, 1-clk pulse after EOP detected.
REQ-007 SHALL have ports rx_data_i (in, 1) and rx_den_i (in, 1): NRZI-decoded, destuffed bit, LSB-first, valid when rx_den_i=1.
REQ-008 SHALL have port rx_pid_o, out, 4, PID[3:0] of the last packet.
REQ-009 SHALL have port rx_packet_type_o, out, 2, packet type: 0 SOF, 1 TOKEN, 2 DATA, 3 HNDSHK.
REQ-010 SHALL have ports rx_addr_o (out, 7), rx_endp_o (out, 4) and rx_frame_o (out, 11), carrying token and SOF fields.
REQ-011 SHALL have ports rx_byte_o (out, 8) and rx_byte_vld_o (out, 1): DATA payload byte, 1-clk strobe.
REQ-012 SHALL have port rx_byte_cnt_o, out, 11, number of payload bytes emitted in the current/last packet.
REQ-013 SHALL have port rx_pkt_done_o, out, 1, 1-clk pulse; the status outputs below are valid in this cycle.
REQ-014 SHALL have ports rx_pid_error_o, rx_crc_error_o and rx_len_error_o, each out, 1, qualified by rx_pkt_done_o.

Function
REQ-015 FSM states SHALL be IDLE, PID, TOKEN, DATA, HSHK, DROP.
REQ-016 In IDLE, rx_packet_st_i SHALL go to PID and clear the bit counter, the CRC registers and rx_byte_cnt_o; rx_den_i SHALL be ignored in IDLE.
REQ-017 PID SHALL collect 8 bits, and pid_error SHALL be raised if bits[7:4] != ~bits[3:0].
REQ-018 PID type SHALL map as: OUT 0001, IN 1001 and SETUP 1101 to TOKEN; SOF 0101 to SOF (TOKEN state); DATA0 0011 and DATA1 1011 to DATA; ACK 0010, NAK 1010 and STALL 1110 to HSHK; any other value to pid_error.
REQ-019 A pid_error SHALL go to DROP.
REQ-020 TOKEN SHALL take exactly 16 bits: addr[6:0], endp[3:0], crc5[4:0] for token PIDs, or frame[10:0], crc5 for SOF.
REQ-021 CRC5 SHALL use poly x^5+x^2+1 and init 11111, run over all 16 bits, and flag an error unless the residual is 01100.
REQ-022 rx_addr_o, rx_endp_o and rx_frame_o SHALL update only at rx_pkt_done_o of an error-free packet of the matching type, and SHALL hold otherwise.
REQ-023 DATA SHALL assemble bytes LSB-first and run CRC16 (poly 0x8005, init 0xFFFF) over all bits after the PID, requiring residual 0x800D.
REQ-024 DATA SHALL use a 2-byte holdback: a byte SHALL be emitted on rx_byte_vld_o one clk after the byte two positions later completes, so the CRC bytes are never emitted.
REQ-025 When the (MAX_PKT_BYTES+1)th payload byte would be emitted, the block SHALL set len_error, suppress all further emission, and stay in DATA until EOP.
REQ-026 HSHK SHALL raise len_error if any bit arrives after the PID.
REQ-027 DROP SHALL ignore bits until rx_packet_ed_i.
REQ-028 On rx_packet_ed_i in any non-IDLE state, rx_pkt_done_o SHALL pulse the next clk and the FSM SHALL return to IDLE.
REQ-029 len_error SHALL be set at EOP for: TOKEN bit count != 16; DATA bit count not a multiple of 8 or fewer than 16; PID state with fewer than 8 bits.
REQ-030 If rx_den_i and rx_packet_ed_i occur in the same clk, the bit SHALL be consumed first and then the packet finalised.
REQ-031 On rx_packet_st_i in a non-IDLE state, the current packet SHALL finish with done and len_error=1 in the next clk, and the new packet SHALL start in PID in the same clk.
REQ-032 Held-back bytes SHALL be discarded at EOP without emission.
REQ-033 rx_byte_cnt_o SHALL saturate at MAX_PKT_BYTES.

Reset
REQ-034 While rst_i=1, the FSM SHALL be IDLE and all outputs SHALL be 0, with the CRC registers at their init values.
REQ-035 A reset asserted mid-packet SHALL abandon the packet with no done pulse; after release, the block SHALL wait for rx_packet_st_i.

Verification
REQ-036 SETUP bytes 2D 00 10 then EOP SHALL give done with type=1, addr=0, endp=0 and no errors; the same stimulus with last byte 11 SHALL give crc_error=1.
REQ-037 DATA0 bytes C3 80 06 00 01 00 00 40 00 DD 94 then EOP SHALL produce 8 strobes (80 06 00 01 00 00 40 00), cnt=8 and no errors.
REQ-038 ACK D2 then EOP SHALL give type=3 with no errors; D2 plus 3 extra bits SHALL give len_error=1.
REQ-039 A PID byte of 0x3C SHALL give pid_error=1 with zero byte strobes.
REQ-040 With MAX_PKT_BYTES=4, a DATA1 packet of 6 payload bytes plus CRC SHALL give exactly 4 strobes, cnt=4 and len_error=1.
REQ-041 rx_packet_st_i in the middle of a DATA packet followed by a valid ACK SHALL give two done pulses: len_error, then a clean ACK.
